// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset sequencer: drives per-state enables/selects for a shared-memory datapath.
// Latency with mem_ready held high: OP/OP-IMM 4 cycles, LW 5, SW 4, branch 3.
// Backpressure: FETCH/MEM hold while mem_ready=0; after TIMEOUT consecutive stalls the controller enters ERR.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   instr, eq, mem_ready: instruction register contents, ALU equality flag, memory completion
//   mem_req/mem_we/mem_addr_sel, ir_en/mdr_en, pc_en/pc_src: memory and register strobes
//   alu_src/alu_ctrl/imm_src, reg_we/result_src: datapath selects and writeback
//   halted/err/instr_count: status and retired-instruction counter
module multicycle_ctrl #(
    parameter int D_WIDTH = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        instr,
    input  logic               eq,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_en,
    output logic               mdr_en,
    output logic               pc_en,
    output logic               pc_src,
    output logic               alu_src,
    output logic [2:0]         alu_ctrl,
    output logic [2:0]         imm_src,
    output logic               reg_we,
    output logic               result_src,
    output logic               halted,
    output logic               err,
    output logic [D_WIDTH-1:0] instr_count
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] HALT   = 3'd5;
    localparam logic [2:0] ERR    = 3'd6;

    localparam int               WW        = $clog2(TIMEOUT + 1);
    // Value of the wait counter during the last tolerated stall cycle.
    localparam logic [WW-1:0]    WAIT_LAST = WW'(TIMEOUT - 1);

    logic [2:0]         state_q, state_d;
    logic [WW-1:0]      wait_q, wait_d;
    logic [D_WIDTH-1:0] cnt_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_op, is_opimm, alu_legal, is_lw, is_sw, is_br, is_ecall;
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_op     = (opcode == 7'b0110011);
    assign alu_legal = (is_op || is_opimm) &&
                       (funct3 == 3'b000 || funct3 == 3'b110 || funct3 == 3'b111);
    assign is_lw     = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw     = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_br     = (opcode == 7'b1100011) && (funct3 == 3'b000 || funct3 == 3'b001);
    assign is_ecall  = (opcode == 7'b1110011);
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Datapath selects decode straight from instr regardless of state.
    logic       alu_src_d;
    logic [2:0] alu_ctrl_d, imm_src_d;

    always_comb begin
        alu_src_d  = is_opimm | is_lw | is_sw;
        imm_src_d  = 3'b000;
        alu_ctrl_d = 3'b000;
        if (is_sw) imm_src_d = 3'b001;
        else if (is_br) imm_src_d = 3'b010;
        if (is_br) begin
            alu_ctrl_d = 3'b001;
        end else if (is_op || is_opimm) begin
            case (funct3)
                // instr[30] only selects sub for register-register ops; for OP-IMM it is immediate data.
                3'b000:  alu_ctrl_d = (is_op && instr[30]) ? 3'b001 : 3'b000;
                3'b111:  alu_ctrl_d = 3'b010;
                3'b110:  alu_ctrl_d = 3'b011;
                default: alu_ctrl_d = 3'b000;
            endcase
        end
    end

    logic req_d, we_d, addr_sel_d, ir_en_d, mdr_en_d, pc_en_d, pc_src_d, reg_we_d, res_src_d;

    always_comb begin
        state_d    = state_q;
        wait_d     = '0;
        req_d      = 1'b0;
        we_d       = 1'b0;
        addr_sel_d = 1'b0;
        ir_en_d    = 1'b0;
        mdr_en_d   = 1'b0;
        pc_en_d    = 1'b0;
        pc_src_d   = 1'b0;
        reg_we_d   = 1'b0;
        res_src_d  = 1'b0;
        case (state_q)
            FETCH: begin
                req_d = 1'b1;
                if (mem_ready) begin
                    ir_en_d = 1'b1;
                    state_d = DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DECODE: begin
                if (alu_legal || is_lw || is_sw || is_br) state_d = EXEC;
                else if (is_ecall)                        state_d = HALT;
                else                                      state_d = ERR;
            end
            EXEC: begin
                if (is_br) begin
                    pc_en_d  = 1'b1;
                    // funct3[0] distinguishes BNE from BEQ.
                    pc_src_d = funct3[0] ? ~eq : eq;
                    state_d  = FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                req_d      = 1'b1;
                addr_sel_d = 1'b1;
                we_d       = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        pc_en_d = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_en_d = 1'b1;
                        state_d  = WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = ERR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WB: begin
                reg_we_d  = 1'b1;
                res_src_d = is_lw;
                pc_en_d   = 1'b1;
                state_d   = FETCH;
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (pc_en_d) cnt_q <= cnt_q + 1'b1;
        end
    end

    // Every output is forced low while rst is high, including the first reset cycle.
    assign mem_req      = ~rst & req_d;
    assign mem_we       = ~rst & we_d;
    assign mem_addr_sel = ~rst & addr_sel_d;
    assign ir_en        = ~rst & ir_en_d;
    assign mdr_en       = ~rst & mdr_en_d;
    assign pc_en        = ~rst & pc_en_d;
    assign pc_src       = ~rst & pc_src_d;
    assign reg_we       = ~rst & reg_we_d;
    assign result_src   = ~rst & res_src_d;
    assign alu_src      = ~rst & alu_src_d;
    assign alu_ctrl     = rst ? 3'b000 : alu_ctrl_d;
    assign imm_src      = rst ? 3'b000 : imm_src_d;
    assign halted       = ~rst & ((state_q == HALT) || (state_q == ERR));
    assign err          = ~rst & (state_q == ERR);
    assign instr_count  = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = 32'h0;
    logic          eq = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, mem_addr_sel, ir_en, mdr_en, pc_en, pc_src;
    logic          alu_src, reg_we, result_src, halted, err;
    logic [2:0]    alu_ctrl, imm_src;
    logic [DW-1:0] instr_count;

    multicycle_ctrl #(.D_WIDTH(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .instr(instr), .eq(eq), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
        .ir_en(ir_en), .mdr_en(mdr_en), .pc_en(pc_en), .pc_src(pc_src),
        .alu_src(alu_src), .alu_ctrl(alu_ctrl), .imm_src(imm_src),
        .reg_we(reg_we), .result_src(result_src), .halted(halted), .err(err),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // {mem_req, mem_we, mem_addr_sel, ir_en, mdr_en, pc_en, pc_src, reg_we, result_src, halted, err}
    wire [10:0] strb = {mem_req, mem_we, mem_addr_sel, ir_en, mdr_en, pc_en, pc_src,
                        reg_we, result_src, halted, err};

    int errors = 0;
    int checks = 0;

    // Scoreboard of expected retirements: {pc_src, reg_we, result_src}.
    logic [2:0]    exp_q[$];
    logic [2:0]    exp_e;
    logic [DW-1:0] cnt_model = '0;

    always @(negedge clk) begin
        checks++;
        if (instr_count !== (rst ? '0 : cnt_model)) begin
            errors++;
            $display("FAIL instr_count at %0t: got %0d want %0d", $time, instr_count, rst ? '0 : cnt_model);
        end
        if (rst) begin
            cnt_model = '0;
        end else if (pc_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected retire at %0t: pc_en=1 with nothing expected", $time);
            end else begin
                exp_e = exp_q.pop_front();
                if ({pc_src, reg_we, result_src} !== exp_e) begin
                    errors++;
                    $display("FAIL retire at %0t: {pc_src,reg_we,result_src}=%b want %b",
                             $time, {pc_src, reg_we, result_src}, exp_e);
                end
            end
            cnt_model = cnt_model + 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0; eq = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h403100B3; mem_ready = 1'b1; eq = 1'b1;
        tick();
        checks++;
        if ({strb, alu_ctrl, imm_src, alu_src, instr_count} !== '0) begin
            errors++;
            $display("FAIL reset outputs: strb=%h alu_ctrl=%b imm_src=%b alu_src=%b cnt=%0d want all 0",
                     strb, alu_ctrl, imm_src, alu_src, instr_count);
        end
        rst = 1'b0; mem_ready = 1'b0; eq = 1'b0; #1;
        checks++;
        if (strb !== 11'h400) begin
            errors++;
            $display("FAIL reset fetch: strb=%h want 400", strb);
        end
        tick();
    endtask

    task automatic test_addi();
        logic [10:0] ex [4] = '{11'h480, 11'h000, 11'h000, 11'h028};
        do_reset();
        instr = 32'h00500093; mem_ready = 1'b1;
        exp_q.push_back(3'b010);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (strb !== ex[i]) begin
                errors++;
                $display("FAIL addi cycle %0d: strb=%h want %h", i, strb, ex[i]);
            end
            tick();
        end
        checks++;
        if (instr_count !== DW'(1)) begin
            errors++;
            $display("FAIL addi count: got %0d want 1", instr_count);
        end
    endtask

    task automatic test_alu_decode();
        logic [31:0] ins [5] = '{32'h403100B3, 32'h0070F093, 32'h0070E093, 32'h003100B3, 32'h40000093};
        logic [6:0]  sel [5] = '{7'b0_000_001, 7'b1_000_010, 7'b1_000_011, 7'b0_000_000, 7'b1_000_000};
        do_reset();
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = ins[k];
            exp_q.push_back(3'b010);
            for (int c = 0; c < 4; c++) begin
                #1;
                if (c == 2) begin
                    checks++;
                    if ({alu_src, imm_src, alu_ctrl} !== sel[k]) begin
                        errors++;
                        $display("FAIL alu_decode %h: {alu_src,imm_src,alu_ctrl}=%b want %b",
                                 ins[k], {alu_src, imm_src, alu_ctrl}, sel[k]);
                    end
                end
                if (c == 3) begin
                    checks++;
                    if (strb !== 11'h028) begin
                        errors++;
                        $display("FAIL alu_decode wb %h: strb=%h want 028", ins[k], strb);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_lw();
        logic        mr [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        logic [10:0] ex [8] = '{11'h480, 11'h000, 11'h000, 11'h500, 11'h500, 11'h500, 11'h540, 11'h02C};
        do_reset();
        instr = 32'h00002083;
        exp_q.push_back(3'b011);
        for (int i = 0; i < 8; i++) begin
            mem_ready = mr[i]; #1;
            checks++;
            if (strb !== ex[i]) begin
                errors++;
                $display("FAIL lw cycle %0d: strb=%h want %h", i, strb, ex[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alu_src, imm_src, alu_ctrl} !== 7'b1_000_000) begin
                    errors++;
                    $display("FAIL lw selects: %b want 1000000", {alu_src, imm_src, alu_ctrl});
                end
            end
            tick();
        end
        checks++;
        if (instr_count !== DW'(1)) begin
            errors++;
            $display("FAIL lw count: got %0d want 1", instr_count);
        end
    endtask

    task automatic test_sw();
        logic [10:0] ex [4] = '{11'h480, 11'h000, 11'h000, 11'h720};
        do_reset();
        instr = 32'h00102023; mem_ready = 1'b1;
        exp_q.push_back(3'b000);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (strb !== ex[i]) begin
                errors++;
                $display("FAIL sw cycle %0d: strb=%h want %h", i, strb, ex[i]);
            end
            if (i == 2) begin
                checks++;
                if ({alu_src, imm_src, alu_ctrl} !== 7'b1_001_000) begin
                    errors++;
                    $display("FAIL sw selects: %b want 1001000", {alu_src, imm_src, alu_ctrl});
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [6] = '{32'h00101063, 32'h00101063, 32'h00101063,
                                 32'h00100063, 32'h00100063, 32'h00100063};
        logic [10:0] ex  [6] = '{11'h480, 11'h000, 11'h030, 11'h480, 11'h000, 11'h020};
        do_reset();
        mem_ready = 1'b1; eq = 1'b0;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b000);
        for (int i = 0; i < 6; i++) begin
            instr = ins[i]; #1;
            checks++;
            if (strb !== ex[i]) begin
                errors++;
                $display("FAIL branch cycle %0d: strb=%h want %h", i, strb, ex[i]);
            end
            if (i == 2 || i == 5) begin
                checks++;
                if ({alu_src, imm_src, alu_ctrl} !== 7'b0_010_001) begin
                    errors++;
                    $display("FAIL branch selects: %b want 0010001", {alu_src, imm_src, alu_ctrl});
                end
            end
            tick();
        end
        checks++;
        if (instr_count !== DW'(2)) begin
            errors++;
            $display("FAIL branch count: got %0d want 2", instr_count);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        instr = 32'h00500093; mem_ready = 1'b0; #1;
        n = 0;
        while (strb === 11'h400 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 15 || strb !== 11'h003) begin
            errors++;
            $display("FAIL fetch timeout: stall cycles=%0d strb=%h want 15 and 003", n, strb);
        end
        tick(); tick();
        checks++;
        if (strb !== 11'h003) begin
            errors++;
            $display("FAIL err sticky: strb=%h want 003", strb);
        end
        do_reset();
        instr = 32'h00002083; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        n = 0;
        while (strb === 11'h500 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n != 15 || strb !== 11'h003) begin
            errors++;
            $display("FAIL mem timeout: stall cycles=%0d strb=%h want 15 and 003", n, strb);
        end
    endtask

    task automatic test_timeout_edge();
        do_reset();
        instr = 32'h00000073; mem_ready = 1'b0;
        repeat (14) tick();
        mem_ready = 1'b1; #1;
        checks++;
        if (strb !== 11'h480) begin
            errors++;
            $display("FAIL timeout edge fetch: strb=%h want 480", strb);
        end
        tick();
        checks++;
        if (strb !== 11'h000) begin
            errors++;
            $display("FAIL timeout edge decode: strb=%h want 000", strb);
        end
        tick();
        checks++;
        if (strb !== 11'h002) begin
            errors++;
            $display("FAIL timeout edge halt: strb=%h want 002", strb);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [4] = '{32'h00000000, 32'h00109093, 32'h00000083, 32'h00002063};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            instr = ins[k]; mem_ready = 1'b1;
            tick(); tick(); tick();
            checks++;
            if (strb !== 11'h003) begin
                errors++;
                $display("FAIL illegal %h: strb=%h want 003", ins[k], strb);
            end
        end
    endtask

    task automatic test_ecall();
        do_reset();
        instr = 32'h00000073; mem_ready = 1'b1;
        tick(); tick();
        checks++;
        if (strb !== 11'h002) begin
            errors++;
            $display("FAIL ecall: strb=%h want 002", strb);
        end
        tick(); tick();
        checks++;
        if (strb !== 11'h002 || instr_count !== '0) begin
            errors++;
            $display("FAIL halt sticky: strb=%h cnt=%0d want 002 and 0", strb, instr_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; mem_ready = 1'b0; #1;
        checks++;
        if (strb !== 11'h400 || instr_count !== '0) begin
            errors++;
            $display("FAIL reset after halt: strb=%h cnt=%0d want 400 and 0", strb, instr_count);
        end
        tick();
    endtask

    task automatic test_reset_mid_sw();
        do_reset();
        instr = 32'h00102023; mem_ready = 1'b1;
        tick(); tick(); tick();
        mem_ready = 1'b0; #1;
        checks++;
        if (strb !== 11'h700) begin
            errors++;
            $display("FAIL sw mem stall: strb=%h want 700", strb);
        end
        tick();
        rst = 1'b1; mem_ready = 1'b1; #1;
        checks++;
        if (strb !== 11'h000) begin
            errors++;
            $display("FAIL sw during reset: strb=%h want 000", strb);
        end
        tick();
        rst = 1'b0; mem_ready = 1'b0; #1;
        checks++;
        if (strb !== 11'h400 || instr_count !== '0) begin
            errors++;
            $display("FAIL sw after reset: strb=%h cnt=%0d want 400 and 0", strb, instr_count);
        end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        instr = 32'h00100063; mem_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            eq = k[0];
            exp_q.push_back({k[0], 2'b00});
            tick(); tick();
            checks++;
            if (strb !== (k[0] ? 11'h030 : 11'h020)) begin
                errors++;
                $display("FAIL wrap beq %0d: strb=%h want %h", k, strb, k[0] ? 11'h030 : 11'h020);
            end
            tick();
            if (k == 15) begin
                checks++;
                if (instr_count !== '0) begin
                    errors++;
                    $display("FAIL wrap count: got %0d want 0", instr_count);
                end
            end
        end
        checks++;
        if (instr_count !== DW'(1)) begin
            errors++;
            $display("FAIL post-wrap count: got %0d want 1", instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_alu_decode();
        test_lw();
        test_sw();
        test_back_to_back();
        test_timeout();
        test_timeout_edge();
        test_illegal();
        test_ecall();
        test_reset_mid_sw();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expected retirements never seen, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
